// File: rtl/addsub16_pkg.sv
// Shared definitions for the add/sub counter command scheduler:
// opcodes, FSM state encoding and default widths.
package addsub16_pkg;

  localparam int WIDTH_D  = 16;
  localparam int STEP_W_D = 8;

  localparam logic [1:0] OP_LOAD = 2'b00;
  localparam logic [1:0] OP_UP   = 2'b01;
  localparam logic [1:0] OP_DOWN = 2'b10;
  localparam logic [1:0] OP_READ = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  function automatic logic [1:0] onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/addsub16_sched_arb2.sv
// Two-way arbiter, combinational grant; round-robin under ADDSUB16_SCHED_RR_EN,
// otherwise fixed priority to client 0. Pointer advances only on the upd strobe.
module arb2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       upd,
  output logic [1:0] grant
);

`ifdef ADDSUB16_SCHED_RR_EN
  logic ptr;  // client preferred on the next tie

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)
      ptr <= 1'b0;
    else if (upd)
      ptr <= grant[0];
  end
`else
  logic unused_rr;

  always_comb begin
    grant = 2'b00;
    if (req[0])
      grant = 2'b01;
    else if (req[1])
      grant = 2'b10;
  end

  assign unused_rr = &{1'b0, clk, rst, upd};
`endif

endmodule

// File: rtl/addsub16_sched.sv
// Two-client command scheduler driving a shared 16-bit up/down wrap counter.
// GNT one cycle after REQ in IDLE; DONE after LOAD+1 / N steps / same cycle; REQ ignored while busy.
module addsub16_sched
  import addsub16_pkg::*;
#(
  parameter int WIDTH  = WIDTH_D,
  parameter int STEP_W = STEP_W_D
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [1:0]          REQ,
  input  logic [3:0]          OP,
  input  logic [2*WIDTH-1:0]  ARG,
  input  logic [2*STEP_W-1:0] STEPS,
  output logic [1:0]          GNT,
  output logic [1:0]          DONE,
  output logic [WIDTH-1:0]    RESULT,
  output logic                WRAP,
  output logic                CTR_EN,
  output logic                CTR_LOAD,
  output logic                CTR_CTL,
  output logic [WIDTH-1:0]    CTR_DATA,
  input  logic [WIDTH-1:0]    CTR_DOUT,
  input  logic                CTR_COUT
);

  state_t            state;
  logic [1:0]        op_q;
  logic              cl_q;
  logic [STEP_W-1:0] rem_q;
  logic              wrap_q;

  logic [1:0]        arb_gnt;
  logic              arb_upd;
  logic              sel;
  logic [1:0]        req_op;
  logic [WIDTH-1:0]  req_arg;
  logic [STEP_W-1:0] req_steps;

  assign arb_upd   = (state == ST_IDLE) && (arb_gnt != 2'b00);
  assign sel       = arb_gnt[1];
  assign req_op    = sel ? OP[3:2] : OP[1:0];
  assign req_arg   = sel ? ARG[2*WIDTH-1:WIDTH] : ARG[WIDTH-1:0];
  assign req_steps = sel ? STEPS[2*STEP_W-1:STEP_W] : STEPS[STEP_W-1:0];

  arb2 u_arb (
    .clk   (CLK),
    .rst   (RST),
    .req   (REQ),
    .upd   (arb_upd),
    .grant (arb_gnt)
  );

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state    <= ST_IDLE;
      op_q     <= OP_LOAD;
      cl_q     <= 1'b0;
      rem_q    <= '0;
      wrap_q   <= 1'b0;
      GNT      <= 2'b00;
      DONE     <= 2'b00;
      CTR_EN   <= 1'b0;
      CTR_LOAD <= 1'b1;
      CTR_CTL  <= 1'b0;
      CTR_DATA <= '0;
    end else begin
      GNT  <= 2'b00;
      DONE <= 2'b00;
      case (state)
        ST_IDLE: begin
          if (arb_gnt != 2'b00) begin
            op_q   <= req_op;
            cl_q   <= sel;
            rem_q  <= req_steps;
            wrap_q <= 1'b0;
            GNT    <= arb_gnt;
            if (req_op == OP_LOAD) begin
              state    <= ST_EXEC;
              CTR_EN   <= 1'b1;
              CTR_LOAD <= 1'b0;
              CTR_DATA <= req_arg;
            end else if (req_op != OP_READ && req_steps != '0) begin
              state   <= ST_EXEC;
              CTR_EN  <= 1'b1;
              CTR_CTL <= (req_op == OP_UP);
            end else begin
              // READ and zero-step moves complete in the grant cycle
              state <= ST_RESP;
              DONE  <= arb_gnt;
            end
          end
        end
        ST_EXEC: begin
          // boundary flag means the counter wraps at this edge
          if (op_q != OP_LOAD && CTR_COUT)
            wrap_q <= 1'b1;
          rem_q <= rem_q - STEP_W'(1);
          if (op_q == OP_LOAD || rem_q == STEP_W'(1)) begin
            state    <= ST_RESP;
            DONE     <= onehot(cl_q);
            CTR_EN   <= 1'b0;
            CTR_LOAD <= 1'b1;
            CTR_CTL  <= 1'b0;
            CTR_DATA <= '0;
          end
        end
        ST_RESP: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // counter output already reflects the final step once RESP is entered
  assign RESULT = (state == ST_RESP) ? CTR_DOUT : '0;
  assign WRAP   = (state == ST_RESP) && wrap_q;

endmodule

// File: doc/addsub16_sched.md
# addsub16_sched

Two-requester command scheduler for the 16-bit loadable up/down wrap counter. It owns the counter's control pins (enable, active-low load, up/down select, load data), arbitrates between two clients, and executes one command per grant: LOAD, UP by N, DOWN by N, or READ. It reports the final counter value and whether a wrap occurred during the command. Sits between client FSMs and a single shared counter instance.

## Interface
- WIDTH, 16, counter data width
- STEP_W, 8, step-count width
- CLK  in  1  clock, rising edge
- RST  in  1  reset, asynchronous, active-low
- REQ  in  2  per-client request, level
- OP  in  4  per-client opcode, {OP1,OP0}, 2 bits each
- ARG  in  2*WIDTH  per-client load value, {ARG1,ARG0}
- STEPS  in  2*STEP_W  per-client step count, {STEPS1,STEPS0}
- GNT  out  2  one-hot, one-cycle pulse: command captured
- DONE  out  2  one-hot, one-cycle pulse: command complete
- RESULT  out  WIDTH  counter value, valid while DONE!=0
- WRAP  out  1  wrap seen during command, valid while DONE!=0
- CTR_EN  out  1  to counter EN
- CTR_LOAD  out  1  to counter LOAD, active-low (0 = load)
- CTR_CTL  out  1  to counter ctl, 1 = up, 0 = down
- CTR_DATA  out  WIDTH  to counter DATA
- CTR_DOUT  in  WIDTH  from counter DOUT
- CTR_COUT  in  1  from counter COUT (combinational boundary flag)

## Operation
- Opcodes: 00 LOAD ARG; 01 UP STEPS times; 10 DOWN STEPS times; 11 READ.
- FSM states: IDLE, EXEC, RESP.
- IDLE: if any REQ, the arbiter picks client i; at the clock edge, latch OP/ARG/STEPS of i, set GNT[i]=1 for one cycle, and clear the sticky wrap flag.
  - Next state is EXEC for LOAD, or for UP/DOWN with STEPS!=0.
  - Next state is RESP for READ, or for UP/DOWN with STEPS==0.
- EXEC:
  - CTR_EN=1 every cycle.
  - LOAD: CTR_LOAD=0 and CTR_DATA=latched ARG for 1 cycle.
  - UP/DOWN: CTR_LOAD=1 and CTR_CTL=op-up for N=STEPS cycles. The remaining-step counter decrements per cycle; on the last cycle the next state is RESP.
- Wrap flag: set when in EXEC with UP/DOWN and CTR_COUT=1, since the counter wraps at that edge. It is never set by LOAD.
- RESP: DONE[i]=1, RESULT=CTR_DOUT, WRAP=sticky flag; next state is IDLE.
- Outside EXEC: CTR_EN=0, CTR_LOAD=1, CTR_CTL=0, CTR_DATA=0.
- Client REQ handling:
  - A client must drop REQ in the cycle after its GNT unless it issues a new command.
  - OP/ARG/STEPS need only be stable in the cycle REQ is sampled in IDLE.
  - REQ is ignored outside IDLE.
- Arithmetic wraps modulo 2^WIDTH. UP 3 from FFFE yields 0001 with WRAP=1; DOWN from 0000 yields FFFF with WRAP=1.

## Timing
- Reset values: all outputs 0, except CTR_LOAD=1. FSM=IDLE, arbiter pointer=client 0, wrap flag=0.
- Let grant cycle c be the first cycle GNT is high.
  - LOAD: EXEC in cycle c, DONE at c+1.
  - UP/DOWN N: EXEC in c..c+N-1, DONE at c+N.
  - READ or N=0: DONE at c, together with GNT.
- REQ sampled in IDLE at cycle k gives GNT at k+1.
- After DONE there is one IDLE cycle; the earliest next GNT is DONE+2.
- RST asserted mid-command: immediate abort. FSM goes to IDLE and control outputs go to reset values. No DONE is issued; the client must re-request. The counter shares RST and clears to 0.
- Simultaneous REQ[0] and REQ[1]: resolved per Configuration. Exactly one GNT bit is ever high.

## Configuration
- ADDSUB16_SCHED_RR_EN defined: round-robin arbitration.
  - The pointer moves to the other client after each grant.
  - On a tie, the client not granted last wins; the first tie after reset goes to client 0.
- Not defined: fixed priority, client 0 always wins. No pointer register is implemented.

## Structure
- Package addsub16_pkg:
  - opcode constants OP_LOAD/OP_UP/OP_DOWN/OP_READ
  - FSM state encoding (ST_IDLE, ST_EXEC, ST_RESP)
  - default WIDTH/STEP_W
- Sub-module arb2: 2-way arbiter with REQ in, one-hot GRANT out, and an update strobe. The round-robin pointer inside it is under the macro.
- The counter is instantiated outside this block and connected through the CTR_* ports.

## Test plan
- Reset, then client 0 LOAD 1234 → GNT=01 in cycle c; DONE=01 at c+1 with RESULT=1234, WRAP=0.
- LOAD FFFE, then UP 3 → DONE at GNT+3, RESULT=0001, WRAP=1.
- LOAD 0002, then DOWN 2 → RESULT=0000, WRAP=0; then DOWN 1 → RESULT=FFFF, WRAP=1.
- READ and UP 0 → GNT and DONE in the same cycle; RESULT unchanged; CTR_EN never asserted.
- Both REQ held high for four commands → with RR_EN, grants are 01,10,01,10; without it, grants are 01,01,01,01.
- UP 200 with RST pulled low at GNT+50 → no DONE; all outputs at reset values; after release, READ returns 0000.
